// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: frame constants, the default port-width
// typedefs and the 3-input majority helper.
package uart_rx_pkg;
  localparam int PRESC_MIN       = 4;
  localparam int UART_FRAME_BITS = 11;
  localparam int PRESC_W_DEF     = 6;
  localparam int BIT_CNT_W_DEF   = 4;

  typedef logic [PRESC_W_DEF-1:0]   presc_t;
  typedef logic [BIT_CNT_W_DEF-1:0] bit_cnt_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversample edge / bit-period counter for the UART RX sampler.
// Latches the effective ratio P when samp_en rises (LSB dropped, clamped to
// PRESC_MIN), runs edge_cnt 0..P-1 and bit_cnt 0..FRAME_BITS-1, and pulses
// frame_done for one cycle after the last bit period ends.
// Ports:
//   clk, rst          oversampling clock, synchronous active-high reset
//   samp_en           run enable from the RX FSM
//   prescale          requested oversample ratio
//   edge_cnt          edge index within current bit
//   half              P>>1 for the ratio in force this cycle (mid-bit index)
//   bit_cnt           bit index within frame
//   frame_done        one-cycle end-of-frame strobe
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W    = 6,
  parameter int BIT_CNT_W  = 4,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 samp_en,
  input  logic [PRESC_W-1:0]   prescale,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [PRESC_W-1:0]   half,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 frame_done
);

  logic [PRESC_W-1:0]   p_q, p_d, p_raw;
  logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 en_prev_q, en_prev_d;
  logic                 en_rise, wrap;

  always_comb begin
    en_rise = samp_en & ~en_prev_q;
    p_raw   = prescale & ~PRESC_W'(1);
    if (p_raw < PRESC_W'(PRESC_MIN)) p_raw = PRESC_W'(PRESC_MIN);
    // The new ratio is used in the rise cycle itself so the mid-bit compare
    // in the top never sees a stale (possibly zero) ratio.
    p_d       = en_rise ? p_raw : p_q;
    wrap      = (edge_cnt_q == p_d - PRESC_W'(1));
    en_prev_d = samp_en;

    edge_cnt_d   = '0;
    bit_cnt_d    = '0;
    frame_done_d = 1'b0;
    if (samp_en) begin
      if (wrap) begin
        if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q          <= '0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      en_prev_q    <= 1'b0;
    end else begin
      p_q          <= p_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      en_prev_q    <= en_prev_d;
    end
  end

  assign edge_cnt   = edge_cnt_q;
  assign half       = p_d >> 1;
  assign bit_cnt    = bit_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/rx_data_sampler.sv
// UART RX oversampling front end. Counts oversample edges and bit periods,
// votes RX_IN at mid-bit and presents sampled_bit with a one-cycle bit_ready
// strobe (at edge_cnt == H+1, H = P>>1) to the deserializer and checkers.
// Build option: define RX_MAJORITY_VOTE_EN for a 3-sample majority over
// edges H-2, H-1, H; otherwise RX_IN is sampled once at H.
// Ports:
//   CLK, RST      oversampling clock, synchronous active-high reset
//   RX_IN         synchronised serial line (idle high)
//   samp_en       run enable from the RX FSM
//   prescale      oversample ratio (even 4..32)
//   edge_cnt      edge index within current bit
//   bit_cnt       bit index within frame (0 = start)
//   sampled_bit   voted bit, held between strobes
//   bit_ready     one-cycle strobe, sampled_bit freshly updated
//   frame_done    one-cycle strobe, last bit period ended
module rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W    = 6,
  parameter int BIT_CNT_W  = 4,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 samp_en,
  input  logic [PRESC_W-1:0]   prescale,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sampled_bit,
  output logic                 bit_ready,
  output logic                 frame_done
);

  logic [PRESC_W-1:0] half;
  logic               sampled_bit_q, sampled_bit_d;
  logic               bit_ready_q, bit_ready_d;
  logic               mid_hit;

  rx_edge_bit_counter #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (BIT_CNT_W),
    .FRAME_BITS(FRAME_BITS)
  ) u_cnt (
    .clk       (CLK),
    .rst       (RST),
    .samp_en   (samp_en),
    .prescale  (prescale),
    .edge_cnt  (edge_cnt),
    .half      (half),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

  // Decision only counts while enabled: a vote at H with samp_en low is dropped.
  assign mid_hit = samp_en && (edge_cnt == half);

`ifdef RX_MAJORITY_VOTE_EN
  logic s0_q, s0_d, s1_q, s1_d;

  always_comb begin
    s0_d          = s0_q;
    s1_d          = s1_q;
    sampled_bit_d = sampled_bit_q;
    if (samp_en && edge_cnt == half - PRESC_W'(2)) s0_d = RX_IN;
    if (samp_en && edge_cnt == half - PRESC_W'(1)) s1_d = RX_IN;
    if (mid_hit) sampled_bit_d = maj3(s0_q, s1_q, RX_IN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end
`else
  always_comb begin
    sampled_bit_d = sampled_bit_q;
    if (mid_hit) sampled_bit_d = RX_IN;
  end
`endif

  // Registered from the decision edge, so it lands at edge_cnt == H+1
  // (H+1 <= P-1 for P >= 4, so bit_cnt has not advanced yet).
  assign bit_ready_d = mid_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sampled_bit_q <= 1'b0;
      bit_ready_q   <= 1'b0;
    end else begin
      sampled_bit_q <= sampled_bit_d;
      bit_ready_q   <= bit_ready_d;
    end
  end

  assign sampled_bit = sampled_bit_q;
  assign bit_ready   = bit_ready_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
module tb_rx_data_sampler;
  import uart_rx_pkg::*;

  logic     CLK = 1'b0;
  logic     RST = 1'b1;
  logic     RX_IN = 1'b1;
  logic     samp_en = 1'b0;
  presc_t   prescale = '0;
  presc_t   edge_cnt;
  bit_cnt_t bit_cnt;
  logic     sampled_bit, bit_ready, frame_done;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: time since enable, split into bit period and edge.
  int       m_t = 0;
  int       m_P = 4;
  bit       m_prev_en = 0;
  int       m_edge = 0;
  int       m_bit = 0;
  bit       m_sb = 0, m_br = 0, m_fd = 0;
  bit       m_hist [64];

  rx_data_sampler dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .samp_en    (samp_en),
    .prescale   (prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sampled_bit(sampled_bit),
    .bit_ready  (bit_ready),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1, "timeout");
  end

  function automatic int eff_ratio(input int ps);
    int p;
    p = ps - (ps % 2);
    return (p < PRESC_MIN) ? PRESC_MIN : p;
  endfunction

  function automatic logic [11:0] obs();
    return {edge_cnt, bit_cnt, sampled_bit, bit_ready, frame_done};
  endfunction

  function automatic logic [11:0] exp_obs();
    return {6'(m_edge), 4'(m_bit), m_sb, m_br, m_fd};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic tick(input bit r, input bit e, input bit x, input int ps);
    int h, e_now, nb;
    RST = r; samp_en = e; RX_IN = x; prescale = 6'(ps);
    @(posedge CLK);
    if (r) begin
      m_prev_en = 0; m_edge = 0; m_bit = 0; m_sb = 0; m_br = 0; m_fd = 0;
    end else if (!e) begin
      m_prev_en = 0; m_edge = 0; m_bit = 0; m_br = 0; m_fd = 0;
    end else begin
      if (!m_prev_en) begin m_P = eff_ratio(ps); m_t = 0; end
      h = m_P / 2;
      e_now = m_t % m_P;
      m_hist[e_now] = x;
      if (e_now == h) begin
`ifdef RX_MAJORITY_VOTE_EN
        nb = int'(m_hist[h-2]) + int'(m_hist[h-1]) + int'(x);
        m_sb = (nb >= 2);
`else
        nb = 0;
        m_sb = x;
`endif
      end
      m_br = (e_now == h);
      m_t++;
      m_edge = m_t % m_P;
      m_bit = (m_t / m_P) % UART_FRAME_BITS;
      m_fd = (m_t % (UART_FRAME_BITS * m_P)) == 0;
      m_prev_en = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 1, 8);
    tick(1, 1, 1, 8);
    n_chk++;
    if (obs() !== 12'h000) $display("FAIL reset_state: got %h want 000", obs());
    else n_pass++;
    tick(0, 0, 1, 8);
    n_chk++;
    if (obs() !== exp_obs()) $display("FAIL reset_idle: got %h want %h", obs(), exp_obs());
    else n_pass++;
  endtask

  task automatic test_steady_high();
    int strobes = 0;
    for (int i = 0; i < 16; i++) begin
      tick(0, 1, 1, 8);
      n_chk++;
      if (obs() !== exp_obs()) $display("FAIL steady_obs c%0d: got %h want %h", i, obs(), exp_obs());
      else n_pass++;
      if (bit_ready) begin
        strobes++;
        n_chk++;
        if (edge_cnt !== 6'd5 || sampled_bit !== 1'b1 || bit_cnt !== 4'(strobes - 1))
          $display("FAIL steady_strobe: got edge %0d bit %0d sb %b want edge 5 bit %0d sb 1",
                   edge_cnt, bit_cnt, sampled_bit, strobes - 1);
        else n_pass++;
      end
    end
    n_chk++;
    if (strobes !== 2) $display("FAIL steady_count: got %0d strobes want 2", strobes);
    else n_pass++;
    tick(0, 0, 1, 8);
  endtask

  task automatic test_glitch();
    bit want;
`ifdef RX_MAJORITY_VOTE_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, (m_edge == 4) ? 1'b0 : 1'b1, 8);
      n_chk++;
      if (obs() !== exp_obs()) $display("FAIL glitch_obs c%0d: got %h want %h", i, obs(), exp_obs());
      else n_pass++;
    end
    n_chk++;
    if (sampled_bit !== want) $display("FAIL glitch_vote: got %b want %b", sampled_bit, want);
    else n_pass++;
    tick(0, 0, 1, 8);
  endtask

  task automatic test_frame();
    bit bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    bit got [$];
    int fd_cnt = 0, fd_at = -1;
    for (int k = 1; k <= 180; k++) begin
      tick(0, 1, bits[m_bit], 16);
      n_chk++;
      if (obs() !== exp_obs()) $display("FAIL frame_obs c%0d: got %h want %h", k, obs(), exp_obs());
      else n_pass++;
      if (bit_ready && got.size() < 11) got.push_back(sampled_bit);
      if (frame_done) begin
        fd_cnt++; fd_at = k;
        n_chk++;
        if (bit_cnt !== 4'd0) $display("FAIL frame_bitcnt: got %0d want 0", bit_cnt);
        else n_pass++;
      end
    end
    n_chk++;
    if (fd_cnt !== 1 || fd_at !== 176)
      $display("FAIL frame_done: got %0d pulses at %0d want 1 at 176", fd_cnt, fd_at);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== bits[i])
        $display("FAIL frame_bit%0d: got %b want %b", i, (i < got.size()) ? got[i] : 1'bx, bits[i]);
      else n_pass++;
    end
    tick(0, 0, 1, 16);
  endtask

  task automatic test_drop();
    bit held;
    for (int i = 0; i < 300 && !(m_bit == 3 && m_edge == 7); i++)
      tick(0, 1, 1'($urandom_range(0, 1)), 16);
    n_chk++;
    if (edge_cnt !== 6'd7 || bit_cnt !== 4'd3)
      $display("FAIL drop_reach: got edge %0d bit %0d want edge 7 bit 3", edge_cnt, bit_cnt);
    else n_pass++;
    held = sampled_bit;
    tick(0, 0, ~held, 16);
    n_chk++;
    if (obs() !== {6'd0, 4'd0, held, 1'b0, 1'b0})
      $display("FAIL drop_state: got %h want %h", obs(), {6'd0, 4'd0, held, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_presc_change();
    int strobes = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 1'($urandom_range(0, 1)), (i < 10) ? 2 : 32);
      n_chk++;
      if (obs() !== exp_obs()) $display("FAIL presc_obs c%0d: got %h want %h", i, obs(), exp_obs());
      else n_pass++;
      if (bit_ready) begin
        strobes++;
        n_chk++;
        if (edge_cnt !== 6'd3) $display("FAIL presc_strobe: got edge %0d want 3", edge_cnt);
        else n_pass++;
      end
    end
    n_chk++;
    if (strobes !== 10) $display("FAIL presc_count: got %0d strobes want 10", strobes);
    else n_pass++;
    tick(0, 0, 1, 32);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 200 && m_bit != 5; i++) tick(0, 1, 1'($urandom_range(0, 1)), 8);
    n_chk++;
    if (bit_cnt !== 4'd5) $display("FAIL rstmid_reach: got bit %0d want 5", bit_cnt);
    else n_pass++;
    tick(1, 1, 1, 8);
    n_chk++;
    if (obs() !== 12'h000) $display("FAIL rstmid_zero: got %h want 000", obs());
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1'($urandom_range(0, 1)), 8);
      n_chk++;
      if (obs() !== exp_obs()) $display("FAIL rstmid_obs c%0d: got %h want %h", i, obs(), exp_obs());
      else n_pass++;
    end
    tick(0, 0, 1, 8);
  endtask

  task automatic test_random();
    bit en = 1, x = 1;
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) x = ~x;
      tick(($urandom_range(0, 399) == 0), en, x, int'($urandom_range(0, 33)));
      n_chk++;
      if (obs() !== exp_obs()) begin
        if (errs < 10) $display("FAIL random_obs c%0d: got %h want %h", i, obs(), exp_obs());
        errs++;
      end else n_pass++;
    end
    tick(0, 0, 1, 8);
  endtask

  initial begin
    test_reset();
    test_steady_high();
    test_glitch();
    test_frame();
    test_drop();
    test_presc_change();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
